// File: rtl/sha256_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_word_packer
//  Description : Byte-stream to 32-bit word feeder for the sha256 core.
//                Bytes are packed big-endian, buffered in a small word FIFO
//                and presented to the core with last-word / byte-count flags.
//                After the final word the next message is held off until
//                the core reports hash completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_word_packer #(
  parameter int WFIFO_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [1:0]       m_numbyte,
  input  logic             hash_done,
  output logic             busy,
  output logic [CNT_W-1:0] msg_bytes
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PACK      = 2'd1,
    DRAIN     = 2'd2,
    WAIT_HASH = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Only the three most recent bytes need holding; the fourth arrives with the push.
  logic [23:0] acc;
  logic [1:0]  idx;

  logic [31:0]            fifo_data [WFIFO_DEPTH];
  logic [1:0]             fifo_nb   [WFIFO_DEPTH];
  logic [WFIFO_DEPTH-1:0] fifo_last;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;

  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_word;
  logic [1:0]  push_nb;

  // Held low during reset so no byte is taken before the block is initialised.
  assign s_ready   = rst && (state == IDLE || state == PACK) && (count != FULL_COUNT);
  assign accept    = s_valid && s_ready;
  assign push_word = {acc, s_data};
  assign push      = accept && (idx == 2'd3 || s_last);
  assign push_nb   = s_last ? (idx + 2'd1) : 2'd0;

  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? fifo_data[rd_ptr] : 32'd0;
  assign m_last    = m_valid ? fifo_last[rd_ptr] : 1'b0;
  assign m_numbyte = m_valid ? fifo_nb[rd_ptr]   : 2'd0;

  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: hash_done only matters once the final word has left.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = s_last ? DRAIN : PACK;
      PACK:      if (accept && s_last) state_nxt = DRAIN;
      DRAIN:     if (pop && m_last) state_nxt = WAIT_HASH;
      WAIT_HASH: if (hash_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Byte accumulator; cleared whenever a word is pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      if (push) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= push_word[23:0];
        idx <= idx + 2'd1;
      end
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_word;
      fifo_last[wr_ptr] <= s_last;
      fifo_nb[wr_ptr]   <= push_nb;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Message byte counter: restarts on the first byte, saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_bytes <= '0;
    end else if (accept) begin
      if (state == IDLE)         msg_bytes <= CNT_W'(1);
      else if (msg_bytes != '1)  msg_bytes <= msg_bytes + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_word_packer
//  Description : Self-checking bench for sha256_word_packer. A monitor packs
//                accepted bytes into expected words and compares every word
//                the DUT hands over; scenario tasks check control outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [1:0]  m_numbyte;
  logic        hash_done = 1'b0;
  logic        busy;
  logic [31:0] msg_bytes;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  logic [34:0] exp_q[$];
  logic [34:0] exp_w;
  logic [23:0] mdl_acc = '0;
  logic [1:0]  mdl_idx = '0;
  logic [31:0] mdl_w;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;

  sha256_word_packer #(.WFIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_numbyte(m_numbyte),
    .hash_done(hash_done), .busy(busy), .msg_bytes(msg_bytes)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: model packs accepted bytes, compares handed-over words, checks stall hold.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      exp_q.delete();
      mdl_acc = '0;
      mdl_idx = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({m_valid, m_data, m_last, m_numbyte} !== {1'b1, prev_out}) begin
          failures++;
          $display("FAIL stall_hold got=%0b_%h_%0b_%0d want=1_%h_%0b_%0d", m_valid, m_data, m_last,
                   m_numbyte, prev_out[34:3], prev_out[2], prev_out[1:0]);
        end
      end
      if (m_valid && m_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got=%h want=none", m_data);
        end else begin
          exp_w = exp_q.pop_front();
          if ({m_data, m_last, m_numbyte} !== exp_w) begin
            failures++;
            $display("FAIL word got=%h last=%0b nb=%0d want=%h last=%0b nb=%0d", m_data, m_last,
                     m_numbyte, exp_w[34:3], exp_w[2], exp_w[1:0]);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_data, m_last, m_numbyte};
      if (s_valid && s_ready) begin
        mdl_w = {mdl_acc, s_data};
        if (mdl_idx == 2'd3 || s_last) begin
          exp_q.push_back({mdl_w, s_last, s_last ? 2'(mdl_idx + 2'd1) : 2'd0});
          mdl_acc = '0;
          mdl_idx = '0;
        end else begin
          mdl_acc = mdl_w[23:0];
          mdl_idx = mdl_idx + 2'd1;
        end
      end
    end
  end

  // Offer one byte and wait (bounded) for it to be taken.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    #1;
    while (!s_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send_timeout got=s_ready0 want=s_ready1 byte=%h", d);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Wait (bounded) until the word FIFO has emptied.
  task automatic wait_drain();
    int n = 0;
    @(negedge clk); #1;
    while (m_valid && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=m_valid1 want=m_valid0");
    end
  endtask

  task automatic pulse_hash();
    @(negedge clk); hash_done = 1'b1;
    @(negedge clk); hash_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (s_ready !== 1'b0)   begin failures++; $display("FAIL rst_s_ready got=%0b want=0", s_ready); end
    checks++; if (m_valid !== 1'b0)   begin failures++; $display("FAIL rst_m_valid got=%0b want=0", m_valid); end
    checks++; if (m_data !== 32'd0)   begin failures++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    checks++; if (m_last !== 1'b0)    begin failures++; $display("FAIL rst_m_last got=%0b want=0", m_last); end
    checks++; if (m_numbyte !== 2'd0) begin failures++; $display("FAIL rst_m_numbyte got=%0d want=0", m_numbyte); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%0b want=0", busy); end
    checks++; if (msg_bytes !== 0)    begin failures++; $display("FAIL rst_msg_bytes got=%0d want=0", msg_bytes); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (s_ready !== 1'b1)   begin failures++; $display("FAIL rst_release_s_ready got=%0b want=1", s_ready); end
  endtask

  task automatic test_abc();
    m_ready = 1'b1;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    checks++; if (m_data !== 32'h0061_6263) begin failures++; $display("FAIL abc_data got=%h want=00616263", m_data); end
    checks++; if (m_last !== 1'b1)    begin failures++; $display("FAIL abc_last got=%0b want=1", m_last); end
    checks++; if (m_numbyte !== 2'd3) begin failures++; $display("FAIL abc_numbyte got=%0d want=3", m_numbyte); end
    wait_drain();
    checks++; if (msg_bytes !== 3)    begin failures++; $display("FAIL abc_msg_bytes got=%0d want=3", msg_bytes); end
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL abc_busy got=%0b want=1", busy); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b0)   begin failures++; $display("FAIL abc_hold_s_ready got=%0b want=0", s_ready); end
    pulse_hash();
    checks++; if (s_ready !== 1'b1)   begin failures++; $display("FAIL abc_after_hash_s_ready got=%0b want=1", s_ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL abc_after_hash_busy got=%0b want=0", busy); end
  endtask

  task automatic test_eight();
    int p0 = pops;
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7);
    wait_drain();
    checks++; if (pops - p0 !== 2)    begin failures++; $display("FAIL eight_words got=%0d want=2", pops - p0); end
    checks++; if (msg_bytes !== 8)    begin failures++; $display("FAIL eight_msg_bytes got=%0d want=8", msg_bytes); end
    pulse_hash();
  endtask

  task automatic test_full_stall();
    int p0 = pops;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    checks++; if (s_ready !== 1'b0)   begin failures++; $display("FAIL full_s_ready got=%0b want=0", s_ready); end
    checks++; if (m_data !== 32'h0001_0203) begin failures++; $display("FAIL full_head got=%h want=00010203", m_data); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b0)   begin failures++; $display("FAIL full_s_ready_hold got=%0b want=0", s_ready); end
    fork
      begin
        for (int i = 16; i < 64; i++) send_byte(8'(i), i == 63);
      end
      begin
        repeat (3) @(negedge clk);
        m_ready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (pops - p0 !== 16)   begin failures++; $display("FAIL full_words got=%0d want=16", pops - p0); end
    checks++; if (msg_bytes !== 64)   begin failures++; $display("FAIL full_msg_bytes got=%0d want=64", msg_bytes); end
    pulse_hash();
  endtask

  task automatic test_toggle();
    int p0 = pops;
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i), i == 19);
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();
    checks++; if (pops - p0 !== 5)    begin failures++; $display("FAIL toggle_words got=%0d want=5", pops - p0); end
    checks++; if (msg_bytes !== 20)   begin failures++; $display("FAIL toggle_msg_bytes got=%0d want=20", msg_bytes); end
    pulse_hash();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 1'b0);
    checks++; if (m_valid !== 1'b1)   begin failures++; $display("FAIL mid_pre_valid got=%0b want=1", m_valid); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (m_valid !== 1'b0)   begin failures++; $display("FAIL mid_m_valid got=%0b want=0", m_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_busy got=%0b want=0", busy); end
    checks++; if (msg_bytes !== 0)    begin failures++; $display("FAIL mid_msg_bytes got=%0d want=0", msg_bytes); end
    checks++; if (s_ready !== 1'b0)   begin failures++; $display("FAIL mid_s_ready got=%0b want=0", s_ready); end
    @(negedge clk); rst = 1'b1; m_ready = 1'b1;
    send_byte(8'hFF, 1'b1);
    checks++; if (m_data !== 32'h0000_00FF) begin failures++; $display("FAIL mid_new_data got=%h want=000000ff", m_data); end
    checks++; if (m_numbyte !== 2'd1) begin failures++; $display("FAIL mid_new_numbyte got=%0d want=1", m_numbyte); end
    checks++; if (m_last !== 1'b1)    begin failures++; $display("FAIL mid_new_last got=%0b want=1", m_last); end
    checks++; if (msg_bytes !== 1)    begin failures++; $display("FAIL mid_new_msg_bytes got=%0d want=1", msg_bytes); end
    wait_drain();
    pulse_hash();
  endtask

  task automatic test_hash_ignored();
    logic [7:0] b [8];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(b[i], 1'b0);
    pulse_hash();
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL ign_busy got=%0b want=1", busy); end
    checks++; if (s_ready !== 1'b1)   begin failures++; $display("FAIL ign_s_ready got=%0b want=1", s_ready); end
    checks++; if (msg_bytes !== 3)    begin failures++; $display("FAIL ign_msg_bytes got=%0d want=3", msg_bytes); end
    for (int i = 3; i < 8; i++) send_byte(b[i], i == 7);
    checks++; if (m_data !== 32'h5566_7788) begin failures++; $display("FAIL ign_data got=%h want=55667788", m_data); end
    checks++; if (m_last !== 1'b1)    begin failures++; $display("FAIL ign_last got=%0b want=1", m_last); end
    wait_drain();
    checks++; if (msg_bytes !== 8)    begin failures++; $display("FAIL ign_msg_bytes_end got=%0d want=8", msg_bytes); end
    pulse_hash();
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL ign_busy_end got=%0b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_eight();
    test_full_stall();
    test_toggle();
    test_reset_mid();
    test_hash_ignored();
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_words got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
